pipelined_addsub: RTL

- Parametrised, pipelined add/subtract unit. Successor to the bit-serial-carry ripple subtractor used in the FIR datapath.
- Adds run-time add/sub mode select, signed/unsigned operand extension, and a carry chain split into registered segments for timing closure.
- Uses a valid/ready handshake with backpressure and a sideband tag passed through alongside each operand pair.
- Sits between the tap multipliers and the accumulator tree.

---
 rtl/pipelined_addsub.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/pipelined_addsub.sv
// Pipelined add/subtract unit with run-time mode select, signed/unsigned extension
// and a carry chain split into registered segments, behind a valid/ready handshake.
module pipelined_addsub #(
    parameter int IN_DATAWIDTH  = 8,
    parameter int OUT_DATAWIDTH = IN_DATAWIDTH + 1,
    parameter int STAGES        = 2,
    parameter int SIGNED        = 1,
    parameter int TAG_WIDTH     = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [IN_DATAWIDTH-1:0]  in1,
    input  logic [IN_DATAWIDTH-1:0]  in2,
    input  logic                     cin,
    input  logic                     sub,
    input  logic [TAG_WIDTH-1:0]     in_tag,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [OUT_DATAWIDTH-1:0] sum,
    output logic [TAG_WIDTH-1:0]     out_tag
);

    localparam int W = IN_DATAWIDTH;
    localparam int C = (W + STAGES - 1) / STAGES;

    logic       advance;
    logic [W:0] ext1;
    logic [W:0] ext2;
    logic [W:0] op_a;
    logic [W:0] op_b;
    logic       carry0;

    assign advance  = !out_valid || out_ready;
    assign in_ready = advance;

    // Subtraction reuses the adder: a - b - borrow == a + ~b + ~borrow.
    assign ext1   = (SIGNED != 0) ? {in1[W-1], in1} : {1'b0, in1};
    assign ext2   = (SIGNED != 0) ? {in2[W-1], in2} : {1'b0, in2};
    assign op_a   = ext1;
    assign op_b   = sub ? ~ext2 : ext2;
    assign carry0 = sub ? ~cin : cin;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int LO_RAW = k * C;
        localparam int LO     = (LO_RAW < W) ? LO_RAW : W;
        localparam int HI_RAW = (k + 1) * C;
        localparam int HI     = (k == STAGES - 1) ? W + 1 : ((HI_RAW < W) ? HI_RAW : W);
        localparam int SEG    = HI - LO;

        logic                 valid_in;
        logic [W:0]           a_in;
        logic [W:0]           b_in;
        logic [W:0]           res_in;
        logic                 carry_in;
        logic [TAG_WIDTH-1:0] tag_in;

        logic [W:0]           res_next;
        logic                 carry_out;

        logic                 valid_q;
        logic [W:0]           res_q;
        logic [TAG_WIDTH-1:0] tag_q;
        logic [W:0]           a_q;
        logic [W:0]           b_q;
        logic                 carry_q;

        if (k == 0) begin : g_src_in
            assign valid_in = in_valid;
            assign a_in     = op_a;
            assign b_in     = op_b;
            assign carry_in = carry0;
            assign res_in   = '0;
            assign tag_in   = in_tag;
        end else begin : g_src_prev
            assign valid_in = g_stage[k-1].valid_q;
            assign a_in     = g_stage[k-1].a_q;
            assign b_in     = g_stage[k-1].b_q;
            assign carry_in = g_stage[k-1].carry_q;
            assign res_in   = g_stage[k-1].res_q;
            assign tag_in   = g_stage[k-1].tag_q;
        end

        // A stage can own zero operand bits when C*STAGES overshoots W; it then just forwards the carry.
        if (SEG > 0) begin : g_seg
            logic [SEG:0] seg;

            assign seg = {1'b0, a_in[LO +: SEG]} + {1'b0, b_in[LO +: SEG]} + {{SEG{1'b0}}, carry_in};

            always_comb begin
                res_next               = res_in;
                res_next[LO +: SEG]    = seg[SEG-1:0];
            end

            assign carry_out = seg[SEG];
        end else begin : g_pass
            assign res_next  = res_in;
            assign carry_out = carry_in;
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                valid_q <= 1'b0;
                res_q   <= '0;
                tag_q   <= '0;
            end else if (advance) begin
                valid_q <= valid_in;
                if (valid_in) begin
                    res_q <= res_next;
                    tag_q <= tag_in;
                end
            end
        end

        if (k < STAGES - 1) begin : g_fwd
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    a_q     <= '0;
                    b_q     <= '0;
                    carry_q <= 1'b0;
                end else if (advance && valid_in) begin
                    a_q     <= a_in;
                    b_q     <= b_in;
                    carry_q <= carry_out;
                end
            end
        end else begin : g_last
            // The final stage drops the carry-out of bit W and the consumed operand bits.
            logic unused_tail;

            assign a_q         = '0;
            assign b_q         = '0;
            assign carry_q     = 1'b0;
            assign unused_tail = ^{a_q, b_q, carry_q, carry_out, a_in, b_in};
        end
    end

    assign out_valid = g_stage[STAGES-1].valid_q;
    assign sum       = g_stage[STAGES-1].res_q;
    assign out_tag   = g_stage[STAGES-1].tag_q;

endmodule
